// File: rtl/mul2x2_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier that time-shares one external 2x2 multiplier,
// one digit pair per cycle. Optional macro MUL2X2_SEQ_ZERO_SKIP_EN short-cuts zero operands.
module mul2x2_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [1:0]           pp_a,
  output logic [1:0]           pp_b,
  input  logic [3:0]           pp_p,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]   i, j;
  logic [PW-1:0]   acc, term, acc_nx;
  logic [IW:0]     pos;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic            last_pair;

`ifdef MUL2X2_SEQ_ZERO_SKIP_EN
  logic zero_op;
  assign zero_op = (a == '0) || (b == '0);
`endif

  // Digit weight of the current pair is 2*(i+j) bit positions.
  assign pos       = {1'b0, i} + {1'b0, j};
  assign term      = PW'(pp_p) << {pos, 1'b0};
  assign acc_nx    = acc + term;
  assign a_sh      = a_reg >> {i, 1'b0};
  assign b_sh      = b_reg >> {j, 1'b0};
  assign last_pair = (i == IW'(D - 1)) && (j == IW'(D - 1));

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    pp_a     = 2'b00;
    pp_b     = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MUL2X2_SEQ_ZERO_SKIP_EN
          state_nx = zero_op ? DONE : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        pp_a = a_sh[1:0];
        pp_b = b_sh[1:0];
        if (last_pair) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state <= state_nx;
      // done is high exactly for the DONE cycle, alongside the fresh product.
      done  <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
`ifdef MUL2X2_SEQ_ZERO_SKIP_EN
            if (zero_op) product <= '0;
`endif
          end
        end
        RUN: begin
          acc <= acc_nx;
          if (last_pair) product <= acc_nx;
          if (j == IW'(D - 1)) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul2x2_seq_ctrl.sv
// Bench for mul2x2_seq_ctrl: directed cases plus random operands against an arithmetic model;
// honours MUL2X2_SEQ_ZERO_SKIP_EN when defined.
module tb_mul2x2_seq_ctrl;
  parameter int W = 4;
  localparam int D = W / 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a, b;
  logic [1:0]     pp_a, pp_b;
  logic [3:0]     pp_p;
  logic           busy, done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_prod;

  mul2x2_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .pp_a(pp_a), .pp_b(pp_b), .pp_p(pp_p),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  // Behavioural 2x2 multiplier.
  assign pp_p = {2'b00, pp_a} * {2'b00, pp_b};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef MUL2X2_SEQ_ZERO_SKIP_EN
    if (av == 0 || bv == 0) return 1;
`endif
    return D * D + 1;
  endfunction

  // Runs one operation; latency counts edges from the start edge (inclusive) to done.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit disturb);
    logic [63:0] ax, bx;
    int cyc, k, lat;
    bit seen;
    ax  = 64'(av);
    bx  = 64'(bv);
    lat = exp_latency(av, bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc <= D * D + 4) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        k = cyc - 1;
        check("busy_run", 64'(busy), 64'd1);
        check("hold_product", 64'(product), 64'(exp_prod));
        if (k < D * D) begin
          check("pp_a_digit", 64'(pp_a), (ax >> (2 * (k / D))) % 4);
          check("pp_b_digit", 64'(pp_b), (bx >> (2 * (k % D))) % 4);
        end
        if (disturb) begin
          start = (cyc == 2);
          a = W'($urandom);
          b = W'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    exp_prod = (2 * W)'(ax * bx);
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(cyc), 64'(lat));
    check("product", 64'(product), 64'(exp_prod));
    check("busy_done", 64'(busy), 64'd1);
    check("pp_idle_done", {62'd0, pp_a == 2'b00, pp_b == 2'b00}, 64'd3);
    @(posedge clk); #1;
    check("done_pulse_end", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("product_after", 64'(product), 64'(exp_prod));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    exp_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", 64'(product), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pp", {60'd0, pp_a, pp_b}, 64'd0);
    @(negedge clk); rst = 1'b0;

    do_op(W'(3), W'(2), 1'b0);
    do_op(W'(15), W'(15), 1'b0);
    do_op(W'(10), W'(13), 1'b0);
    do_op(W'(7), W'(9), 1'b1);

    // Reset in the second RUN cycle discards the operation.
    @(negedge clk); a = W'(12); b = W'(12); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    exp_prod = '0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_product", 64'(product), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pp", {60'd0, pp_a, pp_b}, 64'd0);
    rst = 1'b0;
    for (int n = 0; n < D * D + 2; n++) begin
      @(posedge clk); #1;
      check("no_done_after_rst", 64'(done), 64'd0);
      check("idle_after_rst", 64'(busy), 64'd0);
    end

    do_op(W'(2), W'(3), 1'b0);
    do_op(W'(0), W'(11), 1'b0);
    do_op(W'(5), W'(0), 1'b0);
    do_op('1, '1, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 9) == 0) ra = '0;
      do_op(ra, rb, $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
